// File: rtl/sysid_check_pkg.sv
// Shared types and sizing helpers for the system-ID checker.
package sysid_check_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RD_ID  = 2'd1,
      RD_TS  = 2'd2,
      FINISH = 2'd3
   } state_t;

   localparam logic ADDR_ID = 1'b0;
   localparam logic ADDR_TS = 1'b1;
   localparam int   DATA_W  = 32;

   // Bits needed to hold 0..maxval, never less than one.
   function automatic int cnt_w(input int maxval);
      int w;
      w = 1;
      while ((1 << w) <= maxval) w = w + 1;
      return w;
   endfunction

endpackage

// File: rtl/sysid_check_timer.sv
// Saturating stall counter: clr reloads zero, en counts, expired flags the limit.
module sysid_check_timer
   import sysid_check_pkg::*;
#(
   parameter int LIMIT = 1023,
   parameter int W     = cnt_w(LIMIT)
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam logic [W-1:0] LIM = W'(LIMIT);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en && (cnt != LIM)) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign expired = (cnt == LIM);

endmodule

// File: rtl/sysid_check.sv
// Avalon-MM read master that fetches the system ID and build timestamp and
// compares them with the values this software build expects.
module sysid_check
   import sysid_check_pkg::*;
#(
   parameter logic [31:0] EXPECTED_ID    = 32'd1306474855,
   parameter logic [31:0] EXPECTED_TS    = 32'd1305651299,
   parameter bit          CHECK_TS       = 1'b1,
   parameter bit          AUTO_START     = 1'b1,
   parameter int          TIMEOUT_CYCLES = 1023,
   parameter int          MAX_RETRIES    = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   output logic        avm_address,
   output logic        avm_read,
   input  logic [31:0] avm_readdata,
   input  logic        avm_waitrequest,
   output logic        busy,
   output logic        done,
   output logic        id_ok,
   output logic        ts_ok,
   output logic        pass,
   output logic        timeout,
   output logic [31:0] id_value,
   output logic [31:0] ts_value
);

   localparam int            RW    = cnt_w(MAX_RETRIES);
   localparam logic [RW-1:0] MAX_R = RW'(MAX_RETRIES);

   state_t        state, state_n;
   logic          gap, gap_n;
   logic          auto_pend;
   logic [RW-1:0] retry_cnt, retry_n;
   logic          tmr_clr, tmr_en, expired;
   logic          go, cap_id, cap_ts, to_set;

   sysid_check_timer #(.LIMIT(TIMEOUT_CYCLES)) u_timer (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (tmr_clr),
      .en      (tmr_en),
      .expired (expired)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         gap       <= 1'b0;
         auto_pend <= AUTO_START;
         retry_cnt <= '0;
      end else begin
         state     <= state_n;
         gap       <= gap_n;
         retry_cnt <= retry_n;
         if (go) auto_pend <= 1'b0;
      end
   end

   // The expiry cycle itself doubles as the idle cycle before a retry.
   always_comb begin
      state_n     = state;
      gap_n       = gap;
      retry_n     = retry_cnt;
      avm_read    = 1'b0;
      avm_address = ADDR_ID;
      tmr_clr     = 1'b1;
      tmr_en      = 1'b0;
      go          = 1'b0;
      cap_id      = 1'b0;
      cap_ts      = 1'b0;
      to_set      = 1'b0;
      case (state)
         IDLE: begin
            if (start || auto_pend) begin
               state_n = RD_ID;
               gap_n   = 1'b0;
               retry_n = '0;
               go      = 1'b1;
            end
         end
         RD_ID, RD_TS: begin
            avm_address = (state == RD_TS) ? ADDR_TS : ADDR_ID;
            if (gap) begin
               gap_n = 1'b0;
            end else if (expired) begin
               if (retry_cnt < MAX_R) begin
                  retry_n = retry_cnt + 1'b1;
                  state_n = RD_ID;
               end else begin
                  state_n = FINISH;
                  to_set  = 1'b1;
               end
            end else begin
               avm_read = 1'b1;
               tmr_clr  = 1'b0;
               tmr_en   = avm_waitrequest;
               if (!avm_waitrequest) begin
                  if (state == RD_ID) begin
                     cap_id  = 1'b1;
                     state_n = RD_TS;
                     gap_n   = 1'b1;
                  end else begin
                     cap_ts  = 1'b1;
                     state_n = FINISH;
                  end
               end
            end
         end
         FINISH: state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // pass is resolved on entry to FINISH so it is valid alongside done.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         id_ok    <= 1'b0;
         ts_ok    <= 1'b0;
         pass     <= 1'b0;
         timeout  <= 1'b0;
         id_value <= '0;
         ts_value <= '0;
      end else begin
         if (go) begin
            id_ok   <= 1'b0;
            ts_ok   <= 1'b0;
            pass    <= 1'b0;
            timeout <= 1'b0;
         end
         if (cap_id) begin
            id_value <= avm_readdata;
            id_ok    <= (avm_readdata == EXPECTED_ID);
         end
         if (cap_ts) begin
            ts_value <= avm_readdata;
            ts_ok    <= (avm_readdata == EXPECTED_TS);
            pass     <= id_ok && ((avm_readdata == EXPECTED_TS) || !CHECK_TS);
         end
         if (to_set) begin
            timeout <= 1'b1;
            pass    <= 1'b0;
         end
      end
   end

   assign busy = (state != IDLE);
   assign done = (state == FINISH);

endmodule

// File: doc/sysid_check.md
Name: sysid_check

Overview:
- Avalon-MM read master that sits directly upstream of the system-ID slave (1-bit address, 32-bit readdata) and consumes what it returns.
- After reset, or on request, it reads word 0 (system ID) and word 1 (build timestamp) and compares each against the expected values.
- It latches both words and drives sticky pass/fail/timeout flags for the status LEDs and the host CSR bank.
- Its purpose is to catch a mismatched FPGA image and software build before the SS-OCT acquisition path is enabled.

Parameters:
- EXPECTED_ID, 1306474855, system-ID value required at word 0.
- EXPECTED_TS, 1305651299, build timestamp required at word 1.
- CHECK_TS, 1, 1 = a timestamp mismatch fails the check; 0 = timestamp is only recorded.
- AUTO_START, 1, 1 = a check starts on the first cycle after reset release.
- TIMEOUT_CYCLES, 1023, maximum cycles one read may stall on waitrequest; must be at least 1.
- MAX_RETRIES, 2, re-attempts of a whole check after a timeout.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse; requests a check
- avm_address  out  1  0 = ID word, 1 = timestamp word
- avm_read  out  1  Avalon read strobe
- avm_readdata  in  32  slave read data
- avm_waitrequest  in  1  slave stall
- busy  out  1  check in progress
- done  out  1  single-cycle pulse when a check ends (pass, fail or timeout)
- id_ok  out  1  sticky; last check matched the ID
- ts_ok  out  1  sticky; last check matched the timestamp
- pass  out  1  sticky; id_ok and (ts_ok or CHECK_TS=0)
- timeout  out  1  sticky; last check exhausted its retries
- id_value  out  32  ID word captured by the last check
- ts_value  out  32  timestamp word captured by the last check

Behaviour:
- Clock and reset: one clock, clk; reset_n is asynchronous and active-low.
- Reset values: every output is 0; FSM in IDLE; timeout and retry counters at 0.
- AUTO_START=1: a check begins in the first clk cycle after reset_n deasserts. AUTO_START=0: checks begin only on start.
- States: IDLE, RD_ID, RD_TS, FINISH.
- IDLE -> RD_ID on start or on the auto-start. On this transition: clear id_ok, ts_ok, pass and timeout; load retry_cnt = 0.
- RD_ID:
  - avm_read=1 and avm_address=0 are held stable while avm_waitrequest=1.
  - The transfer completes in a cycle with avm_read=1 and avm_waitrequest=0. In that cycle readdata is captured into id_value, id_ok is set to (readdata == EXPECTED_ID), and the FSM moves to RD_TS.
  - avm_read drops for at least one cycle between the two reads.
- RD_TS: identical to RD_ID with avm_address=1; captures ts_value and ts_ok, then moves to FINISH.
- Timeout counter:
  - Clears on entry to each read state and counts each cycle in which waitrequest=1.
  - When it reaches TIMEOUT_CYCLES, avm_read deasserts.
  - If retry_cnt < MAX_RETRIES: increment retry_cnt and restart at RD_ID after one idle cycle.
  - Otherwise: set timeout=1 and go to FINISH; id_value and ts_value keep their last captured values.
- FINISH: a one-cycle state. pass is set to id_ok and (ts_ok or !CHECK_TS), but is forced to 0 if timeout=1. done pulses for one cycle, then the FSM returns to IDLE.
- busy = 1 in RD_ID, RD_TS and FINISH.
- Latency: with no stall, start (cycle 0) -> read ID (cycle 1) -> gap (cycle 2) -> read TS (cycle 3) -> done (cycle 4).
- A start while busy=1 is ignored and not queued.
- A start coinciding with done is ignored. A new start is accepted from the next cycle.
- A reset_n assertion mid-read aborts immediately: avm_read=0 asynchronously and all flags are cleared.
- Counter widths: the timeout counter is $clog2(TIMEOUT_CYCLES+1) bits; retry_cnt is $clog2(MAX_RETRIES+1) bits, minimum 1. Neither counter wraps; both saturate at their compare value.

Decomposition:
- Package sysid_check_pkg holds:
  - the state enum (IDLE, RD_ID, RD_TS, FINISH), 2-bit encoding;
  - localparams ADDR_ID=1'b0 and ADDR_TS=1'b1;
  - a width helper function for the counter sizes.
- One natural sub-module: sysid_check_timer, a loadable saturating stall counter with clear, enable and expired outputs. It is reused by both read states.

Test Plan:
- Slave returns 1306474855 then 1305651299 with waitrequest=0, AUTO_START=1 -> after reset release: done pulse at cycle 4; pass=1, id_ok=1, ts_ok=1; id_value and ts_value equal the returned words.
- Slave returns ID 1306474856 -> id_ok=0, pass=0, timeout=0; id_value=1306474856.
- ID matches, timestamp returned as 0, run once with CHECK_TS=1 and once with CHECK_TS=0 -> ts_ok=0 in both runs; pass=0 with CHECK_TS=1 and pass=1 with CHECK_TS=0.
- waitrequest held high for 3 cycles on each read -> address and read stable throughout; done at cycle 10; pass=1.
- waitrequest stuck at 1, TIMEOUT_CYCLES=4, MAX_RETRIES=2 -> three read attempts observed; timeout=1, pass=0, exactly one done pulse.
- reset_n asserted while RD_TS is stalled -> avm_read falls without waiting for clk; all flags 0; a fresh auto-check runs after release and passes.
